// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the shift-register load sequencer.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck,
        StGap
    } state_e;

    // Bit-counter width: wide enough to hold 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftreg_seq_ctrl.sv
// Loads a parallel word into a serial-in shift register one bit per clock,
// then reads the register back and reports done plus a match flag.
module shiftreg_seq_ctrl
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_data_i,
    input  logic             req_dir_i,
    input  logic             abort_i,
    output logic             sr_en_o,
    output logic             sr_dir_o,
    output logic             sr_data_o,
    input  logic [WIDTH-1:0] sr_q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             match_o,
    output logic [WIDTH-1:0] word_o
);

    localparam int unsigned    CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [7:0]     GapLast = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic             sr_en_q, sr_en_d;
    logic             sr_dir_q, sr_dir_d;
    logic             sr_data_q, sr_data_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;

    logic [CntW-1:0]  nxt_idx;
    logic [WIDTH-1:0] shifted;
    logic             next_bit;

    // Pick the next serial bit: LSB-first walks upward, MSB-first walks downward.
    always_comb begin
        nxt_idx  = cnt_q + 1'b1;
        shifted  = dir_q ? (word_q >> nxt_idx) : (word_q << nxt_idx);
        next_bit = dir_q ? shifted[0] : shifted[WIDTH-1];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        word_d     = word_q;
        dir_d      = dir_q;
        sr_en_d    = sr_en_q;
        sr_dir_d   = sr_dir_q;
        sr_data_d  = sr_data_q;
        done_d     = 1'b0;
        match_d    = match_q;
        word_out_d = word_out_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    word_d    = req_data_i;
                    dir_d     = req_dir_i;
                    sr_en_d   = 1'b1;
                    sr_dir_d  = req_dir_i;
                    sr_data_d = req_dir_i ? req_data_i[0] : req_data_i[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Abort takes priority over the final shift edge.
                if (abort_i) begin
                    sr_en_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    sr_en_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d     = nxt_idx;
                    sr_data_d = next_bit;
                end
            end
            StCheck: begin
                word_out_d = sr_q_i;
                match_d    = (sr_q_i == word_q);
                done_d     = 1'b1;
                gap_d      = '0;
                state_d    = (IDLE_GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gap_q      <= '0;
            word_q     <= '0;
            dir_q      <= 1'b0;
            sr_en_q    <= 1'b0;
            sr_dir_q   <= 1'b0;
            sr_data_q  <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            word_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            word_q     <= word_d;
            dir_q      <= dir_d;
            sr_en_q    <= sr_en_d;
            sr_dir_q   <= sr_dir_d;
            sr_data_q  <= sr_data_d;
            done_q     <= done_d;
            match_q    <= match_d;
            word_out_q <= word_out_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign sr_en_o     = sr_en_q;
    assign sr_dir_o    = sr_dir_q;
    assign sr_data_o   = sr_data_q;
    assign done_o      = done_q;
    assign match_o     = match_q;
    assign word_o      = word_out_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench: each controller drives a behavioural shift register.
module tb_shiftreg_seq_ctrl;

    localparam int unsigned W = 8;

    logic         clk, rstn;
    int           n_vec = 0;
    int           n_err = 0;

    // Controller with no idle gap.
    logic         valid, ready, dir, abort, en, sdir, sdata, busy, done, match, force_ff;
    logic [W-1:0] data, sr_q, sr_q_mux, word;

    // Controller with IDLE_GAP = 2.
    logic         valid_g, ready_g, en_g, sdir_g, sdata_g, busy_g, done_g, match_g;
    logic [W-1:0] data_g, sr_q_g, word_g;

    shiftreg_seq_ctrl #(.WIDTH(W), .IDLE_GAP(0)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data), .req_dir_i(dir),
        .abort_i(abort), .sr_en_o(en), .sr_dir_o(sdir), .sr_data_o(sdata),
        .sr_q_i(sr_q_mux), .busy_o(busy), .done_o(done), .match_o(match), .word_o(word)
    );

    shiftreg_seq_ctrl #(.WIDTH(W), .IDLE_GAP(2)) dut_g (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(valid_g), .req_ready_o(ready_g), .req_data_i(data_g), .req_dir_i(1'b0),
        .abort_i(1'b0), .sr_en_o(en_g), .sr_dir_o(sdir_g), .sr_data_o(sdata_g),
        .sr_q_i(sr_q_g), .busy_o(busy_g), .done_o(done_g), .match_o(match_g), .word_o(word_g)
    );

    assign sr_q_mux = force_ff ? 8'hFF : sr_q;

    // Behavioural shift registers: dir 0 enters bit 0, dir 1 enters bit W-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q   <= '0;
            sr_q_g <= '0;
        end else begin
            if (en)   sr_q   <= sdir   ? {sdata, sr_q[W-1:1]}     : {sr_q[W-2:0], sdata};
            if (en_g) sr_q_g <= sdir_g ? {sdata_g, sr_q_g[W-1:1]} : {sr_q_g[W-2:0], sdata_g};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[7] is the first serial bit expected on sr_data_o.
    task automatic run_word(input logic [W-1:0] wd, input logic wdir, input logic [W-1:0] seq,
                            input logic [W-1:0] exp_word, input logic exp_match);
        check_eq("ready_before", 32'(ready), 32'd1);
        valid = 1'b1;
        data  = wd;
        dir   = wdir;
        tick();
        valid = 1'b0;
        data  = ~wd;
        dir   = ~wdir;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("en_%0d", k), 32'(en), 32'd1);
            check_eq($sformatf("bit_%0d", k), 32'(sdata), 32'(seq[7-k]));
            check_eq($sformatf("dir_%0d", k), 32'(sdir), 32'(wdir));
            tick();
        end
        check_eq("en_off", 32'(en), 32'd0);
        check_eq("done_early", 32'(done), 32'd0);
        tick();
        check_eq("done", 32'(done), 32'd1);
        check_eq("match", 32'(match), 32'(exp_match));
        check_eq("word", 32'(word), 32'(exp_word));
        check_eq("ready_after", 32'(ready), 32'd1);
        tick();
        check_eq("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int  second;
        int  low_cnt;
        logic saw_done;

        rstn = 1'b0; valid = 1'b0; data = '0; dir = 1'b0; abort = 1'b0; force_ff = 1'b0;
        valid_g = 1'b0; data_g = '0;
        #12;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_en", 32'(en), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_match", 32'(match), 32'd0);
        check_eq("rst_word", 32'(word), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 1: MSB first.
        run_word(8'hA5, 1'b0, 8'b1010_0101, 8'hA5, 1'b1);
        // 2: LSB first.
        run_word(8'h3C, 1'b1, 8'b0011_1100, 8'h3C, 1'b1);
        // 3: corrupted readback.
        force_ff = 1'b1;
        run_word(8'h0F, 1'b0, 8'b0000_1111, 8'hFF, 1'b0);
        force_ff = 1'b0;

        // 5: abort at the third shift edge.
        valid = 1'b1; data = 8'hA5; dir = 1'b0;
        tick();
        valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_en", 32'(en), 32'd0);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);
        check_eq("abort_word", 32'(word), 32'hFF);
        run_word(8'hC4, 1'b1, 8'b0010_0011, 8'hC4, 1'b1);

        // 6: reset at the fifth shift edge.
        valid = 1'b1; data = 8'hE7; dir = 1'b0;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        @(posedge clk);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_en", 32'(en), 32'd0);
        check_eq("mid_rst_dir", 32'(sdir), 32'd0);
        check_eq("mid_rst_data", 32'(sdata), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_match", 32'(match), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_word", 32'(word), 32'd0);
        check_eq("mid_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        run_word(8'h81, 1'b0, 8'b1000_0001, 8'h81, 1'b1);

        // 4: IDLE_GAP = 2, valid held high across two words.
        valid_g = 1'b1;
        data_g  = 8'h6B;
        check_eq("gap_ready0", 32'(ready_g), 32'd1);
        tick();
        second  = 0;
        low_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (ready_g) begin
                second = i;
                break;
            end
            low_cnt++;
            tick();
        end
        check_eq("gap_spacing", 32'(second), 32'd12);
        check_eq("gap_ready_low", 32'(low_cnt), 32'd11);
        tick();
        valid_g = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("gap_done_early", 32'(done_g), 32'd0);
        tick();
        check_eq("gap_done", 32'(done_g), 32'd1);
        check_eq("gap_match", 32'(match_g), 32'd1);
        check_eq("gap_word", 32'(word_g), 32'h6B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shiftreg_seq_ctrl.md
Name: shiftreg_seq_ctrl

Overview:
Sequencer that loads parallel words into the team's N-bit serial-in shift_register, one bit per clock. It accepts a word over a valid/ready handshake and drives the register's en/dir/data pins for exactly WIDTH cycles. It then reads back the register's parallel output, compares it with the word it sent, and reports done plus a match flag. It sits between a parallel producer and a shift_register instance, typically in a serial-link or config-chain wrapper.

Parameters:
WIDTH, 8, shift register length in bits; legal range is WIDTH >= 2.
IDLE_GAP, 0, idle cycles inserted after each word before the next one is accepted; legal range is 0 to 255.

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rstn_i  in  1  asynchronous active-low reset.
req_valid_i  in  1  producer has a word.
req_ready_o  out  1  controller can accept a word; equal to (state == IDLE).
req_data_i  in  WIDTH  word to load.
req_dir_i  in  1  0 = left shift (new bit enters bit 0); 1 = right shift (new bit enters bit WIDTH-1).
abort_i  in  1  cancel the word in progress.
sr_en_o  out  1  to shift_register en_i.
sr_dir_o  out  1  to shift_register dir_i.
sr_data_o  out  1  to shift_register data_i.
sr_q_i  in  WIDTH  from shift_register data_o.
busy_o  out  1  state != IDLE.
done_o  out  1  one-cycle pulse: check complete.
match_o  out  1  valid when done_o = 1; sr_q_i equalled the latched word.
word_o  out  WIDTH  sr_q_i captured at the check; holds its value until the next done_o.

Behaviour:
- FSM states: IDLE, SHIFT, CHECK, GAP. The state register, counters, and all sr_*, done_o, match_o and word_o outputs are registered.
- Reset (async, any state):
  - state = IDLE; bit counter and gap counter = 0.
  - sr_en_o, sr_dir_o, sr_data_o, done_o, match_o, busy_o = 0; word_o = 0.
  - req_ready_o = 1.
- IDLE:
  - A handshake occurs when req_valid_i and req_ready_o are both 1 at a clock edge (E0).
  - At E0 the controller latches the word and direction and moves to SHIFT.
  - At E0 it also sets sr_en_o = 1, sr_dir_o = latched direction, and sr_data_o = first bit.
- Bit order:
  - dir = 0: MSB first (bit WIDTH-1 down to bit 0).
  - dir = 1: LSB first (bit 0 up to bit WIDTH-1).
  - In both cases the register holds the word unpermuted after WIDTH shifts.
- SHIFT:
  - sr_en_o stays high for exactly WIDTH cycles; the shift register captures at edges E1..EWIDTH.
  - Bit counter: $clog2(WIDTH+1) bits, counts 0 to WIDTH-1, no wrap.
  - At EWIDTH: sr_en_o = 0, state = CHECK.
  - sr_dir_o is constant for the whole word.
- CHECK (one cycle):
  - At E(WIDTH+1): word_o = sr_q_i; match_o = (sr_q_i == latched word); done_o = 1 for one cycle.
  - Next state is GAP if IDLE_GAP > 0, otherwise IDLE.
- GAP: counts IDLE_GAP cycles, then goes to IDLE.
- Throughput:
  - With IDLE_GAP = 0, a handshake is possible at E(WIDTH+2); words are spaced WIDTH+2 cycles apart.
  - In general, words are spaced WIDTH+2+IDLE_GAP cycles apart.
- abort_i:
  - Sampled only in SHIFT. If high at an edge: sr_en_o = 0 at that edge, state goes to IDLE, no done_o, word_o unchanged.
  - Ignored in IDLE, CHECK and GAP.
- Simultaneous abort_i and the final shift edge: abort wins; no CHECK.
- Reset mid-word: everything returns to IDLE immediately. The shift register contents are the instance's own responsibility.
- req_data_i and req_dir_i changing after the handshake have no effect on the word in progress.

Decomposition:
- shiftreg_pkg: state enum typedef (IDLE/SHIFT/CHECK/GAP), plus a constant function for the counter width.
- No sub-module inside the controller. The test wrapper pairs one shiftreg_seq_ctrl with one shift_register (MSB = WIDTH).

Test Plan:
1. Reset, then request 8'hA5 with dir = 0:
   - sr_data_o sequence is 1,0,1,0,0,1,0,1 and sr_en_o is high for 8 cycles.
   - done_o at E9 with match_o = 1 and word_o = 8'hA5.
2. Request 8'h3C with dir = 1:
   - sr_data_o sequence is 0,0,1,1,1,1,0,0 and sr_dir_o = 1 throughout.
   - done_o with match_o = 1 and word_o = 8'h3C.
3. Bench forces sr_q_i to 8'hFF during CHECK for word 8'h0F: done_o = 1, match_o = 0, word_o = 8'hFF.
4. IDLE_GAP = 2 with req_valid_i held high on two words: the second handshake occurs exactly 12 cycles after the first, and req_ready_o is low for 11 cycles.
5. abort_i at the 3rd shift edge: sr_en_o is low after that edge, no done_o pulse, req_ready_o = 1, and the next word completes normally.
6. rstn_i asserted at the 5th shift edge: all outputs are 0 immediately and req_ready_o = 1; after release, the word 8'h81 loads and checks with match_o = 1.
